voice_mixer: RTL and testbench
==============================

# voice_mixer

Downstream stage of the wavetable oscillator. It takes the per-voice 16-bit samples and mixes them into a stereo pair of 16-bit outputs for the audio output stage. Each voice has its own left and right gain, and a master gain applies after the sum. Accumulation is sequential (one multiply-accumulate per voice per cycle), and the outputs saturate with sticky clip flags. Gains are programmed over a Wishbone slave port.

## Interface
Parameters:
- NUM_VOICES, 8, number of voice inputs (1..16)
- ACC_W, 32, accumulator width; must be ≥ 24+clog2(NUM_VOICES)

Ports:
- clk  in  1  system clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- mix_start_i  in  1  one-cycle pulse: voice_in holds a new sample set
- voice_in  in  16*NUM_VOICES  signed samples; voice v occupies [16v+15:16v]
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone classic slave controls
- wb_adr_i  in  32  byte address; only [7:2] is decoded
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  ack
- mix_l_o, mix_r_o  out  16  signed mixed outputs
- mix_valid_o  out  1  one-cycle pulse: mix_l_o/mix_r_o were updated
- busy_o  out  1  high while a mix is in progress

## Operation
Register map:
- 0x00 CTRL: [0] enable (reset 1).
- 0x04 MASTER: [7:0] master gain, unsigned, 0x80 = unity (reset 0x80).
- 0x08 STATUS: [0] clip_l, [1] clip_r, [2] overrun (all sticky, write-1-to-clear); [3] busy (read-only).
- 0x10+4v VOICE_GAIN[v]: [7:0] gain_l, [15:8] gain_r, unsigned, 0x80 = unity (reset 0x8080).
- Unused register bits read 0. Unmapped addresses, and v ≥ NUM_VOICES, read 0xDEADBEEF; writes to them are ignored.

State machine: IDLE → ACCUM → MASTER → SAT → IDLE.
- IDLE, on mix_start_i && enable:
  - snapshot voice_in, all voice gains and master gain;
  - clear acc_l and acc_r;
  - idx=0, go to ACCUM.
- ACCUM, per cycle:
  - acc_l += s[idx]*gain_l[idx] and acc_r += s[idx]*gain_r[idx], signed × unsigned giving a 24-bit signed product, sign-extended to ACC_W;
  - idx++; after idx = NUM_VOICES-1, go to MASTER.
- MASTER: m_l = (acc_l >>> 7) * master and m_r = (acc_r >>> 7) * master, signed; go to SAT.
- SAT:
  - r = m >>> 7; saturate r to [-32768, 32767];
  - set clip_l/clip_r if saturation occurred;
  - register mix_l_o/mix_r_o, pulse mix_valid_o, return to IDLE.
- All shifts are arithmetic (floor), with no rounding.
- Snapshots isolate the mix in progress from voice_in changes and register writes; new values take effect at the next mix_start_i.
- mix_start_i while not in IDLE: the pulse is ignored, overrun is set, and the mix in progress completes unaffected.
- mix_start_i with enable=0: the pulse is ignored with no overrun; outputs hold their last values.
- Clearing enable mid-mix does not abort the mix.
- Simultaneous W1C write to STATUS and a new clip/overrun event in the same cycle: the set wins.

## Timing
- Latency: mix_start_i sampled at edge 0 → mix_valid_o high for exactly one cycle after edge NUM_VOICES+2. With NUM_VOICES=8 that is edge 10; minimum frame spacing is NUM_VOICES+3 cycles.
- busy_o goes high after edge 0 and low after edge NUM_VOICES+2, in the same cycle mix_valid_o pulses.
- mix_l_o/mix_r_o change only in the cycle mix_valid_o is high and hold otherwise.
- Wishbone: wb_ack_o = registered (cyc && stb && !ack), so one wait state and an ack at most every other cycle.
  - Writes commit on the ack cycle.
  - wb_dat_o is registered in the cycle before the ack.
- Reset (rst high at any edge, including mid-mix):
  - state → IDLE;
  - mix_l_o, mix_r_o, mix_valid_o, busy_o, wb_ack_o, wb_dat_o = 0;
  - all registers return to their reset values; no mix_valid_o pulse for the aborted frame.

## Test plan
- Voice0=0x1000, VOICE_GAIN[0]=0x4080, all other gains 0, master 0x80, pulse start → after 10 edges mix_l_o=0x1000, mix_r_o=0x0800, one-cycle mix_valid_o, clip flags clear.
- All 8 voices=0x7FFF, all gains 0xFFFF → 0x7FFF/0x7FFF, STATUS=0x3. Then all voices=0x8000 → 0x8000/0x8000. Write 0x3 to STATUS → reads 0x0.
- Master=0x00 with nonzero voices → outputs 0x0000. Master=0x40, voice0=0x2000 at unity gains, others gain 0 → 0x1000.
- Second mix_start_i 3 cycles after the first → single valid pulse carrying the first frame's result, STATUS[2]=1. Change voice_in mid-mix → result unaffected.
- Assert rst at edge 5 of a mix → no valid pulse, outputs 0, MASTER reads 0x80, VOICE_GAIN[3] reads 0x8080, CTRL reads 0x1.
- Read 0x10+4*NUM_VOICES → 0xDEADBEEF. Write CTRL=0, then pulse start → no valid pulse, STATUS[2]=0.

Source files
------------

// File: rtl/voice_mixer.sv
// Stereo voice mixer: sequential per-voice MAC with L/R gains, master gain and
// saturating outputs with sticky clip flags; gains programmed over Wishbone.
module voice_mixer #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned ACC_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mix_start_i,
  input  logic [16*NUM_VOICES-1:0]  voice_in,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [31:0]               wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  output logic                      wb_ack_o,
  output logic [15:0]               mix_l_o,
  output logic [15:0]               mix_r_o,
  output logic                      mix_valid_o,
  output logic                      busy_o
);

  localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned MW   = ACC_W + 2;
  localparam logic [5:0]  GainLo = 6'd4;
  localparam logic [5:0]  GainHi = 6'(4 + NUM_VOICES);
  localparam logic signed [MW-1:0] SatMax = MW'(32767);
  localparam logic signed [MW-1:0] SatMin = MW'(-32768);

  typedef enum logic [1:0] {StIdle, StAccum, StMaster, StSat} state_e;

  state_e state_q, state_d;

  logic                    enable_q, clip_l_q, clip_r_q, ovr_q;
  logic [7:0]              master_q, smaster_q;
  logic [7:0]              gain_l_q [NUM_VOICES];
  logic [7:0]              gain_r_q [NUM_VOICES];
  logic [7:0]              sgain_l_q [NUM_VOICES];
  logic [7:0]              sgain_r_q [NUM_VOICES];
  logic signed [15:0]      samp_q [NUM_VOICES];
  logic [IdxW-1:0]         idx_q;
  logic signed [ACC_W-1:0] acc_l_q, acc_r_q;
  logic signed [MW-1:0]    m_l_q, m_r_q;

  logic load, acc_en, mst_en, sat_en, ovr_set, last_voice;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  assign last_voice = (idx_q == IdxW'(NUM_VOICES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (mix_start_i && enable_q) state_d = StAccum;
      StAccum:  if (last_voice) state_d = StMaster;
      StMaster: state_d = StSat;
      StSat:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    load    = (state_q == StIdle) && mix_start_i && enable_q;
    acc_en  = (state_q == StAccum);
    mst_en  = (state_q == StMaster);
    sat_en  = (state_q == StSat);
    busy_o  = (state_q != StIdle);
    ovr_set = mix_start_i && (state_q != StIdle);
  end

  // Datapath
  logic signed [ACC_W-1:0] samp_ext, gl_ext, gr_ext;
  logic signed [MW-1:0]    sh_l, sh_r, mg_ext, r_l, r_r;
  logic [16:0]             sat_l, sat_r;

  assign samp_ext = ACC_W'(samp_q[idx_q]);
  assign gl_ext   = ACC_W'(sgain_l_q[idx_q]);
  assign gr_ext   = ACC_W'(sgain_r_q[idx_q]);
  assign sh_l     = MW'(acc_l_q >>> 7);
  assign sh_r     = MW'(acc_r_q >>> 7);
  assign mg_ext   = MW'(smaster_q);
  assign r_l      = m_l_q >>> 7;
  assign r_r      = m_r_q >>> 7;

  // {clipped, value}
  function automatic logic [16:0] sat16(input logic signed [MW-1:0] r);
    if (r > SatMax)      return {1'b1, 16'h7fff};
    else if (r < SatMin) return {1'b1, 16'h8000};
    else                 return {1'b0, r[15:0]};
  endfunction

  assign sat_l = sat16(r_l);
  assign sat_r = sat16(r_r);

  // Snapshots need no reset: they are always loaded before use
  always_ff @(posedge clk) begin
    if (load) begin
      smaster_q <= master_q;
      for (int v = 0; v < NUM_VOICES; v++) begin
        samp_q[v]    <= voice_in[16*v +: 16];
        sgain_l_q[v] <= gain_l_q[v];
        sgain_r_q[v] <= gain_r_q[v];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      m_l_q       <= '0;
      m_r_q       <= '0;
      mix_l_o     <= '0;
      mix_r_o     <= '0;
      mix_valid_o <= 1'b0;
    end else begin
      mix_valid_o <= sat_en;
      if (load) begin
        idx_q   <= '0;
        acc_l_q <= '0;
        acc_r_q <= '0;
      end
      if (acc_en) begin
        idx_q   <= idx_q + IdxW'(1);
        acc_l_q <= acc_l_q + samp_ext * gl_ext;
        acc_r_q <= acc_r_q + samp_ext * gr_ext;
      end
      if (mst_en) begin
        m_l_q <= sh_l * mg_ext;
        m_r_q <= sh_r * mg_ext;
      end
      if (sat_en) begin
        mix_l_o <= sat_l[15:0];
        mix_r_o <= sat_r[15:0];
      end
    end
  end

  // Wishbone register file
  logic [5:0]      reg_sel;
  logic [IdxW-1:0] widx;
  logic            gain_hit, req, wr_en;
  logic            wr_ctrl, wr_master, wr_status, wr_gain;
  logic [31:0]     rd_data;
  logic            unused_bits;

  assign unused_bits = ^{wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i[31:16]};
  assign reg_sel     = wb_adr_i[7:2];
  assign gain_hit    = (reg_sel >= GainLo) && (reg_sel < GainHi);
  assign widx        = IdxW'(reg_sel - GainLo);
  assign req         = wb_cyc_i && wb_stb_i;
  assign wr_en       = req && wb_we_i && wb_ack_o;
  assign wr_ctrl     = wr_en && (reg_sel == 6'd0);
  assign wr_master   = wr_en && (reg_sel == 6'd1);
  assign wr_status   = wr_en && (reg_sel == 6'd2);
  assign wr_gain     = wr_en && gain_hit;

  always_comb begin
    rd_data = 32'hdead_beef;
    case (reg_sel)
      6'd0:    rd_data = {31'b0, enable_q};
      6'd1:    rd_data = {24'b0, master_q};
      6'd2:    rd_data = {28'b0, busy_o, ovr_q, clip_r_q, clip_l_q};
      default: if (gain_hit) rd_data = {16'b0, gain_r_q[widx], gain_l_q[widx]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req && !wb_ack_o;
      if (req && !wb_ack_o) wb_dat_o <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= 1'b1;
      master_q <= 8'h80;
      for (int v = 0; v < NUM_VOICES; v++) begin
        gain_l_q[v] <= 8'h80;
        gain_r_q[v] <= 8'h80;
      end
    end else begin
      if (wr_ctrl)   enable_q <= wb_dat_i[0];
      if (wr_master) master_q <= wb_dat_i[7:0];
      if (wr_gain) begin
        gain_l_q[widx] <= wb_dat_i[7:0];
        gain_r_q[widx] <= wb_dat_i[15:8];
      end
    end
  end

  // Later assignments let a new event win over a same-cycle W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (wr_status) begin
        clip_l_q <= clip_l_q & ~wb_dat_i[0];
        clip_r_q <= clip_r_q & ~wb_dat_i[1];
        ovr_q    <= ovr_q & ~wb_dat_i[2];
      end
      if (sat_en && sat_l[16]) clip_l_q <= 1'b1;
      if (sat_en && sat_r[16]) clip_r_q <= 1'b1;
      if (ovr_set)             ovr_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed self-checking bench for voice_mixer (NUM_VOICES=8).
module tb_voice_mixer;

  localparam int unsigned NV = 8;

  logic          clk, rst, mix_start_i;
  logic [16*NV-1:0] voice_in;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0]   wb_adr_i, wb_dat_i, wb_dat_o;
  logic          wb_ack_o;
  logic [15:0]   mix_l_o, mix_r_o;
  logic          mix_valid_o, busy_o;

  int checks = 0;
  int errors = 0;

  voice_mixer #(.NUM_VOICES(NV), .ACC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .mix_start_i (mix_start_i),
    .voice_in    (voice_in),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .mix_l_o     (mix_l_o),
    .mix_r_o     (mix_r_o),
    .mix_valid_o (mix_valid_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All bus tasks enter and leave 1 time unit after a rising edge
  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    bit got = 0;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = adr; wb_dat_i = dat;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin got = 1; break; end
    end
    if (!got) check("wb_write_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    bit got = 0;
    dat = 32'hx;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = adr;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin got = 1; dat = wb_dat_o; break; end
    end
    if (!got) check("wb_read_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wb_cyc_i = 0; wb_stb_i = 0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(adr, d);
    check(tag, d, exp);
  endtask

  task automatic set_voices(input logic [15:0] v0, input logic [15:0] rest);
    voice_in[15:0] = v0;
    for (int v = 1; v < NV; v++) voice_in[16*v +: 16] = rest;
  endtask

  task automatic set_gains(input logic [15:0] g0, input logic [15:0] rest);
    wb_write(32'h10, {16'h0, g0});
    for (int v = 1; v < NV; v++) wb_write(32'h10 + 4 * v, {16'h0, rest});
  endtask

  // Pulse start, expect one valid pulse after edge NV+2 carrying exp_l/exp_r
  task automatic run_mix(input string tag, input logic [15:0] exp_l, input logic [15:0] exp_r);
    int lat = 0;
    logic [15:0] l = 16'hx, r = 16'hx;
    logic busy_at = 1'bx;
    mix_start_i = 1;
    @(posedge clk); #1;
    mix_start_i = 0;
    check({tag, "_busy_start"}, {31'b0, busy_o}, 32'd1);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (mix_valid_o) begin
        lat = n; l = mix_l_o; r = mix_r_o; busy_at = busy_o;
        break;
      end
    end
    check({tag, "_latency"}, lat, NV + 2);
    check({tag, "_l"}, {16'b0, l}, {16'b0, exp_l});
    check({tag, "_r"}, {16'b0, r}, {16'b0, exp_r});
    check({tag, "_busy_at_valid"}, {31'b0, busy_at}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid_one_cycle"}, {31'b0, mix_valid_o}, 32'd0);
  endtask

  initial begin
    int pulses, first_n;
    logic [15:0] pl, pr;
    rst = 1; mix_start_i = 0; voice_in = '0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    check("rst_mix_l", {16'b0, mix_l_o}, 32'd0);
    check("rst_mix_r", {16'b0, mix_r_o}, 32'd0);
    check("rst_valid", {31'b0, mix_valid_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    read_check("rst_ctrl", 32'h00, 32'h1);
    read_check("rst_master", 32'h04, 32'h80);
    read_check("rst_status", 32'h08, 32'h0);
    read_check("rst_gain7", 32'h2C, 32'h8080);

    // Basic: voice0 only, left unity, right half
    set_gains(16'h4080, 16'h0000);
    read_check("gain0_rb", 32'h10, 32'h4080);
    set_voices(16'h1000, 16'h1234);
    run_mix("basic", 16'h1000, 16'h0800);
    read_check("basic_status", 32'h08, 32'h0);

    // Positive and negative saturation
    set_gains(16'hFFFF, 16'hFFFF);
    set_voices(16'h7FFF, 16'h7FFF);
    run_mix("sat_pos", 16'h7FFF, 16'h7FFF);
    read_check("sat_status", 32'h08, 32'h3);
    set_voices(16'h8000, 16'h8000);
    run_mix("sat_neg", 16'h8000, 16'h8000);
    wb_write(32'h08, 32'h3);
    read_check("w1c_status", 32'h08, 32'h0);

    // Master gain
    wb_write(32'h04, 32'h00);
    set_voices(16'h7FFF, 16'h7FFF);
    run_mix("master0", 16'h0000, 16'h0000);
    read_check("master0_status", 32'h08, 32'h0);
    wb_write(32'h04, 32'h40);
    set_gains(16'h8080, 16'h0000);
    set_voices(16'h2000, 16'h7FFF);
    run_mix("master40", 16'h1000, 16'h1000);

    // Overrun plus voice_in change mid-mix
    wb_write(32'h04, 32'h80);
    set_voices(16'h0100, 16'h0000);
    mix_start_i = 1;
    @(posedge clk); #1;
    mix_start_i = 0;
    pulses = 0; first_n = 0; pl = 16'hx; pr = 16'hx;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 2) mix_start_i = 1;
      if (n == 3) mix_start_i = 0;
      if (n == 4) set_voices(16'h7000, 16'h7000);
      if (mix_valid_o) begin
        pulses++;
        if (pulses == 1) begin first_n = n; pl = mix_l_o; pr = mix_r_o; end
      end
    end
    check("ovr_pulses", pulses, 1);
    check("ovr_latency", first_n, NV + 2);
    check("ovr_l", {16'b0, pl}, 32'h0100);
    check("ovr_r", {16'b0, pr}, 32'h0100);
    read_check("ovr_status", 32'h08, 32'h4);
    wb_write(32'h08, 32'h4);
    read_check("ovr_cleared", 32'h08, 32'h0);

    // Reset at edge 5 of a mix
    wb_write(32'h04, 32'h40);
    wb_write(32'h1C, 32'h0000);
    set_voices(16'h0100, 16'h0000);
    mix_start_i = 1;
    @(posedge clk); #1;
    mix_start_i = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      if (mix_valid_o) pulses++;
      @(posedge clk); #1;
    end
    check("rstmix_pulses", pulses, 0);
    check("rstmix_l", {16'b0, mix_l_o}, 32'd0);
    check("rstmix_r", {16'b0, mix_r_o}, 32'd0);
    check("rstmix_busy", {31'b0, busy_o}, 32'd0);
    read_check("rstmix_master", 32'h04, 32'h80);
    read_check("rstmix_gain3", 32'h1C, 32'h8080);
    read_check("rstmix_ctrl", 32'h00, 32'h1);

    // Unmapped addresses, and disabled start
    read_check("unmapped_voice", 32'h10 + 4 * NV, 32'hDEADBEEF);
    read_check("unmapped_0c", 32'h0C, 32'hDEADBEEF);
    wb_write(32'h00, 32'h0);
    read_check("ctrl_off", 32'h00, 32'h0);
    mix_start_i = 1;
    @(posedge clk); #1;
    mix_start_i = 0;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      if (mix_valid_o || busy_o) pulses++;
      @(posedge clk); #1;
    end
    check("disabled_no_activity", pulses, 0);
    read_check("disabled_status", 32'h08, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
